// File: rtl/jk_mod_counter_if.sv
// Purpose: bundle of control inputs and count outputs for jk_mod_counter.
// Ports  : en/up_dn/load/load_val driven by master; q/qb/tc/wrap/load_err driven by slave (counter).
// Modports: master = controller/testbench side, slave = counter side.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  q, qb, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output q, qb, tc, wrap, load_err
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Purpose: modulo-MOD up/down counter built from WIDTH JK stages, with load, terminal count, wrap and load-error flags.
// Latency: one clk from sampled en/load to q/wrap/load_err; qb follows q combinationally, tc is combinational.
// Backpressure: none; en is a count strobe and tc is meant to drive the en of a cascaded stage.
// Ports: clk (rising edge), rst_n (async active-low), bus (slave modport: en, up_dn, load, load_val -> q, qb, tc, wrap, load_err).
module jk_mod_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    jk_mod_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
    // One extra bit so MOD == 2^WIDTH is representable for the range compares.
    localparam logic [WIDTH:0]   MOD_V = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] tog_up, tog_dn;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             load_ok, at_max, at_zero, out_of_range, tc;
    logic             carry, borrow;

    assign load_ok      = ({1'b0, bus.load_val} < MOD_V);
    assign at_max       = (count_q == MAX_V);
    assign at_zero      = (count_q == '0);
    assign out_of_range = ({1'b0, count_q} >= MOD_V);

    assign tc = bus.en & ~bus.load & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

    // Ripple toggle enables: bit i toggles counting up when all lower bits are 1,
    // counting down when all lower bits are 0.
    always_comb begin
        carry  = 1'b1;
        borrow = 1'b1;
        tog_up = '0;
        tog_dn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            tog_up[i] = carry;
            tog_dn[i] = borrow;
            carry     = carry & count_q[i];
            borrow    = borrow & ~count_q[i];
        end
    end

    // J/K drive: 00 hold, 01 clear, 10 set, 11 toggle.
    always_comb begin
        j = '0;
        k = '0;
        if (bus.load) begin
            if (load_ok) begin
                j = bus.load_val;
                k = ~bus.load_val;
            end else begin
                k = '1;
            end
        end else if (bus.en) begin
            if (out_of_range) begin
                // Corrupted state: recover to zero regardless of direction.
                k = '1;
            end else if (bus.up_dn) begin
                if (at_max) begin
                    k = '1;
                end else begin
                    j = tog_up;
                    k = tog_up;
                end
            end else begin
                if (at_zero) begin
                    j = MAX_V;
                    k = ~MAX_V;
                end else begin
                    j = tog_dn;
                    k = tog_dn;
                end
            end
        end
    end

    // JK characteristic equation per bit.
    assign count_d    = (j & ~count_q) | (~k & count_q);
    assign wrap_d     = tc;
    assign load_err_d = bus.load & ~load_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.q        = count_q;
    assign bus.qb       = ~count_q;
    assign bus.tc       = tc;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;
    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   fails;
    logic [3:0] up_tab [12];
    logic [3:0] e;
    logic [3:0] prev;

    jk_mod_counter_if #(.WIDTH(4)) bus ();

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        fails  = 0;
        up_tab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = 4'd0;

        // Reset state
        tick();
        check("rst_q", bus.q, 4'd0);
        check("rst_qb", bus.qb, 4'hF);
        check("rst_wrap", {3'b0, bus.wrap}, 4'd0);
        check("rst_lerr", {3'b0, bus.load_err}, 4'd0);
        rst_n = 1'b1;

        // Up count 12 clocks from 0
        bus.en    = 1'b1;
        bus.up_dn = 1'b1;
        prev      = 4'd0;
        for (int i = 0; i < 12; i++) begin
            check("up_tc", {3'b0, bus.tc}, (prev == 4'd9) ? 4'd1 : 4'd0);
            tick();
            e = ~up_tab[i];
            check("up_q", bus.q, up_tab[i]);
            check("up_qb", bus.qb, e);
            check("up_wrap", {3'b0, bus.wrap}, (up_tab[i] == 4'd0) ? 4'd1 : 4'd0);
            prev = up_tab[i];
        end

        // Continue to 7, then asynchronous reset between edges
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_q", bus.q, 4'd7);
        #3;
        rst_n  = 1'b0;
        bus.en = 1'b0;
        #1;
        check("arst_q", bus.q, 4'd0);
        check("arst_qb", bus.qb, 4'hF);
        check("arst_wrap", {3'b0, bus.wrap}, 4'd0);
        check("arst_lerr", {3'b0, bus.load_err}, 4'd0);
        #2;
        rst_n = 1'b1;

        // Down count: load 0, then count down through the wrap
        bus.load     = 1'b1;
        bus.load_val = 4'd0;
        tick();
        check("ld0_q", bus.q, 4'd0);
        check("ld0_lerr", {3'b0, bus.load_err}, 4'd0);
        bus.load  = 1'b0;
        bus.en    = 1'b1;
        bus.up_dn = 1'b0;
        #1;
        check("dn_tc0", {3'b0, bus.tc}, 4'd1);
        tick();
        check("dn_q9", bus.q, 4'd9);
        check("dn_wrap", {3'b0, bus.wrap}, 4'd1);
        check("dn_tc9", {3'b0, bus.tc}, 4'd0);
        tick();
        check("dn_q8", bus.q, 4'd8);
        check("dn_wrap_clr", {3'b0, bus.wrap}, 4'd0);
        tick();
        check("dn_q7", bus.q, 4'd7);

        // Legal load wins over count
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 4'd5;
        tick();
        check("ld5_q", bus.q, 4'd5);
        bus.en       = 1'b1;
        bus.up_dn    = 1'b1;
        bus.load_val = 4'd3;
        #1;
        check("ld3_tc", {3'b0, bus.tc}, 4'd0);
        tick();
        check("ld3_q", bus.q, 4'd3);
        check("ld3_lerr", {3'b0, bus.load_err}, 4'd0);
        check("ld3_wrap", {3'b0, bus.wrap}, 4'd0);

        // Load at terminal value: tc suppressed, no wrap pulse
        bus.en       = 1'b0;
        bus.load_val = 4'd9;
        tick();
        check("ld9_q", bus.q, 4'd9);
        bus.en       = 1'b1;
        bus.load_val = 4'd2;
        #1;
        check("ld9_tc", {3'b0, bus.tc}, 4'd0);
        tick();
        check("ld2_q", bus.q, 4'd2);
        check("ld2_wrap", {3'b0, bus.wrap}, 4'd0);

        // Illegal loads: 12 and exactly MOD
        bus.en       = 1'b0;
        bus.load_val = 4'd12;
        tick();
        check("ild12_q", bus.q, 4'd0);
        check("ild12_lerr", {3'b0, bus.load_err}, 4'd1);
        bus.load = 1'b0;
        tick();
        check("ild12_lerr_clr", {3'b0, bus.load_err}, 4'd0);
        check("ild12_hold", bus.q, 4'd0);
        bus.load     = 1'b1;
        bus.load_val = 4'd10;
        tick();
        check("ild10_q", bus.q, 4'd0);
        check("ild10_lerr", {3'b0, bus.load_err}, 4'd1);

        // Hold at 4
        bus.load_val = 4'd4;
        tick();
        check("ld4_lerr", {3'b0, bus.load_err}, 4'd0);
        bus.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_q", bus.q, 4'd4);
            check("hold_tc", {3'b0, bus.tc}, 4'd0);
        end

        // Direction flip every cycle
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.up_dn = (i % 2 == 0);
            tick();
            e = (i % 2 == 0) ? 4'd5 : 4'd4;
            check("flip_q", bus.q, e);
            e = ~e;
            check("flip_qb", bus.qb, e);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
